mem_read_arbiter: RTL and testbench

MEM_READ_ARBITER -- requirements
Module: mem_read_arbiter

---
 rtl/mem_read_arbiter_if.sv | 39 +++
 rtl/mem_read_arbiter.sv | 141 ++++++++++++++
 tb/tb_mem_read_arbiter.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_read_arbiter_if.sv
// Bundle of the two requester ports and the Avalon-MM burst read master port.
// The arbiter connects through "master"; the requesters and memory connect through "slave".
interface mem_read_arbiter_if;
   // Handshakes: a requester holds *_do (and its address) as a level until it sees its
   // one-cycle *_done pulse. The arbiter holds avm_read with stable address/burstcount
   // until a cycle with avm_waitrequest=0. Beats are taken only when avm_readdatavalid=1.
   logic          readcode_do;
   logic [31:0]   readcode_address;
   logic          readcode_done;
   logic          readcode_partial_done;
   logic [31:0]   readcode_partial;
   logic [127:0]  readcode_line;

   logic          readline_do;
   logic [31:0]   readline_address;
   logic          readline_done;
   logic [127:0]  readline_line;

   logic [29:0]   avm_address;
   logic          avm_read;
   logic [2:0]    avm_burstcount;
   logic          avm_waitrequest;
   logic [31:0]   avm_readdata;
   logic          avm_readdatavalid;

   modport master (
      input  readcode_do, readcode_address, readline_do, readline_address,
             avm_waitrequest, avm_readdata, avm_readdatavalid,
      output readcode_done, readcode_partial_done, readcode_partial, readcode_line,
             readline_done, readline_line, avm_address, avm_read, avm_burstcount
   );

   modport slave (
      output readcode_do, readcode_address, readline_do, readline_address,
             avm_waitrequest, avm_readdata, avm_readdatavalid,
      input  readcode_done, readcode_partial_done, readcode_partial, readcode_line,
             readline_done, readline_line, avm_address, avm_read, avm_burstcount
   );
endinterface

// File: rtl/mem_read_arbiter.sv
// Round-robin arbiter between a code fetch and a data line fill, sharing one
// Avalon-MM master that issues 4-beat burst reads.
module mem_read_arbiter (
   input  logic                 clk,
   input  logic                 rst_n,
   mem_read_arbiter_if.master   bus,
   output logic [1:0]           o_dbg_state
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2
   } state_t;

   state_t        r_state;
   state_t        w_next_state;

   logic          r_last_code;
   logic          r_is_code;
   logic [1:0]    r_cnt;
   logic [29:0]   r_avm_address;
   logic          r_avm_read;
   logic [2:0]    r_avm_burstcount;
   logic          r_code_done;
   logic          r_code_pdone;
   logic          r_data_done;
   logic [31:0]   r_code_partial;
   logic [127:0]  r_code_line;
   logic [127:0]  r_data_line;

   logic          w_code_req;
   logic          w_data_req;
   logic          w_grant;
   logic          w_grant_code;
   logic          w_accept;
   logic          w_beat;
   logic          w_last_beat;

   // A requester still sees do high during its own done cycle; masking it there
   // keeps the finished request from being granted a second time.
   assign w_code_req = bus.readcode_do & ~r_code_done;
   assign w_data_req = bus.readline_do & ~r_data_done;

   always_comb begin
      w_next_state = r_state;
      w_grant      = 1'b0;
      w_grant_code = 1'b0;
      w_accept     = 1'b0;
      w_beat       = 1'b0;
      w_last_beat  = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_code_req | w_data_req) begin
               w_grant      = 1'b1;
               w_grant_code = w_code_req & (~w_data_req | ~r_last_code);
               w_next_state = ADDR;
            end
         end
         ADDR: begin
            if (!bus.avm_waitrequest) begin
               w_accept     = 1'b1;
               w_next_state = DATA;
            end
         end
         DATA: begin
            if (bus.avm_readdatavalid) begin
               w_beat = 1'b1;
               if (r_cnt == 2'd3) begin
                  w_last_beat  = 1'b1;
                  w_next_state = IDLE;
               end
            end
         end
         default: w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next_state;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_last_code      <= 1'b0;
         r_is_code        <= 1'b0;
         r_cnt            <= 2'd0;
         r_avm_address    <= 30'd0;
         r_avm_read       <= 1'b0;
         r_avm_burstcount <= 3'd0;
         r_code_done      <= 1'b0;
         r_code_pdone     <= 1'b0;
         r_data_done      <= 1'b0;
         r_code_partial   <= 32'd0;
         r_code_line      <= 128'd0;
         r_data_line      <= 128'd0;
      end else begin
         r_code_done  <= 1'b0;
         r_code_pdone <= 1'b0;
         r_data_done  <= 1'b0;
         if (w_grant) begin
            r_is_code        <= w_grant_code;
            r_last_code      <= w_grant_code;
            r_avm_read       <= 1'b1;
            r_avm_burstcount <= 3'd4;
            r_avm_address    <= w_grant_code ? bus.readcode_address[31:2]
                                             : {bus.readline_address[31:4], 2'b00};
         end
         if (w_accept) begin
            r_avm_read <= 1'b0;
            r_cnt      <= 2'd0;
         end
         // The 2-bit counter wraps to 0 on the last beat, the same edge that returns to IDLE.
         if (w_beat) begin
            r_cnt <= r_cnt + 2'd1;
            if (r_is_code) begin
               r_code_line[{r_cnt, 5'd0} +: 32] <= bus.avm_readdata;
               r_code_partial                   <= bus.avm_readdata;
               r_code_done                      <= w_last_beat;
               r_code_pdone                     <= ~w_last_beat;
            end else begin
               r_data_line[{r_cnt, 5'd0} +: 32] <= bus.avm_readdata;
               r_data_done                      <= w_last_beat;
            end
         end
      end
   end

   assign bus.avm_address           = r_avm_address;
   assign bus.avm_read              = r_avm_read;
   assign bus.avm_burstcount        = r_avm_burstcount;
   assign bus.readcode_done         = r_code_done;
   assign bus.readcode_partial_done = r_code_pdone;
   assign bus.readcode_partial      = r_code_partial;
   assign bus.readcode_line         = r_code_line;
   assign bus.readline_done         = r_data_done;
   assign bus.readline_line         = r_data_line;
   assign o_dbg_state               = r_state;

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Directed bench for mem_read_arbiter: bursts, round-robin ties, wait states,
// beat gaps, mid-burst reset and stray readdatavalid.
module tb_mem_read_arbiter;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [1:0]   dbg_state;

   mem_read_arbiter_if bus();

   mem_read_arbiter dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus.master),
      .o_dbg_state (dbg_state)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   logic [127:0] exp_q[$];

   task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [127:0] make_line(input logic [31:0] seed);
      logic [127:0] l;
      l = '0;
      for (int i = 0; i < 4; i++) l[32*i +: 32] = seed * 32'(i + 1);
      return l;
   endfunction

   task automatic check_idle_quiet(input string tag);
      check_val({tag, "_state"},  128'(dbg_state), 128'd0);
      check_val({tag, "_read"},   128'(bus.avm_read), 128'd0);
      check_val({tag, "_cdone"},  128'(bus.readcode_done), 128'd0);
      check_val({tag, "_pdone"},  128'(bus.readcode_partial_done), 128'd0);
      check_val({tag, "_ldone"},  128'(bus.readline_done), 128'd0);
   endtask

   // Called in the cycle the DUT sits in DATA; ends in the done cycle.
   task automatic serve_beats(input bit is_code, input logic [31:0] seed);
      logic [31:0] d;
      exp_q.push_back(make_line(seed));
      for (int i = 0; i < 4; i++) begin
         d = seed * 32'(i + 1);
         bus.avm_readdata = d;
         bus.avm_readdatavalid = 1'b1;
         tick();
         bus.avm_readdatavalid = 1'b0;
         check_val("beat_cdone", 128'(bus.readcode_done), 128'(is_code && i == 3));
         check_val("beat_ldone", 128'(bus.readline_done), 128'(!is_code && i == 3));
         if (is_code) begin
            check_val("beat_pdone",   128'(bus.readcode_partial_done), 128'(i < 3));
            check_val("beat_partial", 128'(bus.readcode_partial), 128'(d));
         end
      end
      check_val("burst_line", is_code ? bus.readcode_line : bus.readline_line, exp_q.pop_front());
      check_val("burst_end_state", 128'(dbg_state), 128'd0);
   endtask

   // Called in the cycle right after the grant edge.
   task automatic serve(input bit is_code, input logic [31:0] seed, input logic [29:0] exp_addr);
      check_val("grant_state", 128'(dbg_state), 128'd1);
      check_val("grant_read",  128'(bus.avm_read), 128'd1);
      check_val("grant_addr",  128'(bus.avm_address), 128'(exp_addr));
      check_val("grant_burst", 128'(bus.avm_burstcount), 128'd4);
      bus.avm_waitrequest = 1'b0;
      tick();
      check_val("accept_state", 128'(dbg_state), 128'd2);
      check_val("accept_read",  128'(bus.avm_read), 128'd0);
      serve_beats(is_code, seed);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   initial begin
      logic [6:0]   pat;
      logic [127:0] gline;
      int           n;

      bus.readcode_do = 1'b0;
      bus.readcode_address = '0;
      bus.readline_do = 1'b0;
      bus.readline_address = '0;
      bus.avm_waitrequest = 1'b0;
      bus.avm_readdata = '0;
      bus.avm_readdatavalid = 1'b0;

      tick();
      tick();
      check_idle_quiet("rst");
      check_val("rst_addr",  128'(bus.avm_address), 128'd0);
      check_val("rst_burst", 128'(bus.avm_burstcount), 128'd0);
      check_val("rst_cline", bus.readcode_line, 128'd0);
      check_val("rst_lline", bus.readline_line, 128'd0);
      check_val("rst_part",  128'(bus.readcode_partial), 128'd0);
      rst_n = 1'b1;
      tick();
      check_idle_quiet("idle_noreq");

      // Single code burst at 0x1234
      bus.readcode_do = 1'b1;
      bus.readcode_address = 32'h0000_1234;
      tick();
      serve(1'b1, 32'h11, 30'h048D);
      check_val("t1_line_const", bus.readcode_line, 128'h00000044_00000033_00000022_00000011);
      bus.readcode_do = 1'b0;
      tick();
      check_idle_quiet("t1_after");

      // Round-robin: tie after reset goes to code, then data, then code again
      do_reset();
      bus.readcode_do = 1'b1;
      bus.readcode_address = 32'h0000_0100;
      bus.readline_do = 1'b1;
      bus.readline_address = 32'h0000_0200;
      tick();
      serve(1'b1, 32'h05, 30'h040);
      bus.readcode_do = 1'b0;
      tick();
      serve(1'b0, 32'h0707, 30'h080);
      check_val("hold_cline", bus.readcode_line, make_line(32'h05));
      bus.readline_do = 1'b0;
      tick();
      check_idle_quiet("rr_gap");
      bus.readcode_do = 1'b1;
      bus.readline_do = 1'b1;
      tick();
      serve(1'b1, 32'h09, 30'h040);
      check_val("hold_lline", bus.readline_line, make_line(32'h0707));
      bus.readcode_do = 1'b0;
      tick();
      serve(1'b0, 32'h0B, 30'h080);
      bus.readline_do = 1'b0;
      tick();

      // Data burst with three wait-state cycles
      bus.readline_do = 1'b1;
      bus.readline_address = 32'h0000_2038;
      bus.avm_waitrequest = 1'b1;
      tick();
      for (int i = 0; i < 4; i++) begin
         bus.avm_waitrequest = (i < 3);
         check_val("wait_read", 128'(bus.avm_read), 128'd1);
         check_val("wait_addr", 128'(bus.avm_address), 128'h080C);
         check_val("wait_burst", 128'(bus.avm_burstcount), 128'd4);
         bus.readline_address = 32'hFFFF_FFF0;
         tick();
      end
      check_val("wait_done_read", 128'(bus.avm_read), 128'd0);
      serve_beats(1'b0, 32'h0D0D);
      bus.readline_do = 1'b0;
      tick();

      // Code burst with gapped beats: valid pattern 1,0,0,1,1,0,1
      bus.readcode_do = 1'b1;
      bus.readcode_address = 32'h0000_0040;
      tick();
      check_val("gap_addr", 128'(bus.avm_address), 128'h010);
      bus.avm_waitrequest = 1'b0;
      tick();
      pat = 7'b1011001;
      gline = '0;
      n = 0;
      for (int i = 0; i < 7; i++) begin
         bus.avm_readdatavalid = pat[i];
         bus.avm_readdata = 32'hC0 + 32'(i);
         if (pat[i]) begin
            gline[32*n +: 32] = 32'hC0 + 32'(i);
            n++;
         end
         tick();
         check_val("gap_pdone", 128'(bus.readcode_partial_done), 128'(pat[i] && n < 4));
         check_val("gap_done",  128'(bus.readcode_done), 128'(pat[i] && n == 4));
      end
      bus.avm_readdatavalid = 1'b0;
      check_val("gap_line", bus.readcode_line, gline);
      bus.readcode_do = 1'b0;
      tick();

      // Reset after beat 2 of a code burst, then stray valid, then a clean burst
      bus.readcode_do = 1'b1;
      bus.readcode_address = 32'h0000_0080;
      tick();
      tick();
      for (int i = 0; i < 2; i++) begin
         bus.avm_readdatavalid = 1'b1;
         bus.avm_readdata = 32'hE0 + 32'(i);
         tick();
      end
      check_val("pre_rst_pdone", 128'(bus.readcode_partial_done), 128'd1);
      rst_n = 1'b0;
      #1;
      check_idle_quiet("mid_rst");
      check_val("mid_rst_line", bus.readcode_line, 128'd0);
      check_val("mid_rst_part", 128'(bus.readcode_partial), 128'd0);
      bus.readcode_do = 1'b0;
      tick();
      rst_n = 1'b1;
      bus.avm_readdatavalid = 1'b1;
      bus.avm_readdata = 32'hDEAD_BEEF;
      tick();
      tick();
      bus.avm_readdatavalid = 1'b0;
      check_idle_quiet("stray");
      check_val("stray_part", 128'(bus.readcode_partial), 128'd0);
      check_val("stray_cline", bus.readcode_line, 128'd0);
      check_val("stray_lline", bus.readline_line, 128'd0);
      bus.readcode_do = 1'b1;
      bus.readcode_address = 32'h0000_1234;
      tick();
      serve(1'b1, 32'h21, 30'h048D);
      bus.readcode_do = 1'b0;
      tick();
      check_idle_quiet("final");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
